jtframe_obj_draw: RTL and testbench

JTFRAME_OBJ_DRAW -- requirements
Module: jtframe_obj_draw

---
 rtl/jtframe_obj_draw_pkg.sv | 13 +
 rtl/jtframe_obj_draw_if.sv | 24 ++
 rtl/jtframe_obj_draw.sv | 97 +++++++++
 tb/tb_jtframe_obj_draw.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/jtframe_obj_draw_pkg.sv
// rtl/jtframe_obj_draw_pkg.sv - shared object-draw state encoding and constants
package jtframe_obj_draw_pkg;

    localparam int PIX_PER_WORD = 8;
    localparam int PIX_CNT_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAW  = 2'd2
    } obj_state_t;

endpackage

// File: rtl/jtframe_obj_draw_if.sv
// rtl/jtframe_obj_draw_if.sv - ROM fetch and line-buffer write bus of the object drawer
interface jtframe_obj_draw_if #(
    parameter int AW   = 9,
    parameter int CW   = 12,
    parameter int PALW = 4
);
    logic [CW:0]     rom_addr;
    logic            rom_cs;
    logic            rom_ok;
    logic [31:0]     rom_data;
    logic [AW-1:0]   buf_addr;
    logic [PALW+3:0] buf_data;
    logic            buf_we;

    modport master (
        output rom_addr, rom_cs, buf_addr, buf_data, buf_we,
        input  rom_ok, rom_data
    );

    modport slave (
        input  rom_addr, rom_cs, buf_addr, buf_data, buf_we,
        output rom_ok, rom_data
    );
endinterface

// File: rtl/jtframe_obj_draw.sv
// rtl/jtframe_obj_draw.sv - fetches two 8-pixel ROM words per object row and writes them to the line buffer
module jtframe_obj_draw
    import jtframe_obj_draw_pkg::*;
#(
    parameter int AW   = 9,
    parameter int CW   = 12,
    parameter int PALW = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    draw,
    input  logic [CW-1:0]           code,
    input  logic [AW-1:0]           xpos,
    input  logic [PALW-1:0]         pal,
    input  logic                    hflip,
    output logic                    busy,
    jtframe_obj_draw_if.master      bus
);

    obj_state_t           state, state_nx;
    logic [CW-1:0]        code_l;
    logic [PALW-1:0]      pal_l;
    logic                 hflip_l;
    logic                 half;
    logic                 word;
    logic [PIX_CNT_W-1:0] cnt;
    logic [31:0]          pix_sr;
    logic [AW-1:0]        addr;
    logic                 last_pix;

    assign last_pix = (cnt == PIX_CNT_W'(PIX_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            code_l  <= '0;
            pal_l   <= '0;
            hflip_l <= 1'b0;
            half    <= 1'b0;
            word    <= 1'b0;
            cnt     <= '0;
            pix_sr  <= '0;
            addr    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (draw) begin
                        code_l  <= code;
                        pal_l   <= pal;
                        hflip_l <= hflip;
                        half    <= hflip;
                        word    <= 1'b0;
                        cnt     <= '0;
                        addr    <= xpos;
                    end
                end
                ST_FETCH: begin
                    if (bus.rom_ok) begin
                        pix_sr <= bus.rom_data;
                        cnt    <= '0;
                    end
                end
                ST_DRAW: begin
                    // The address counter runs straight across both words, so word 1 lands at xpos+8
                    addr   <= addr + AW'(1);
                    cnt    <= cnt + PIX_CNT_W'(1);
                    pix_sr <= hflip_l ? (pix_sr >> 4) : (pix_sr << 4);
                    if (last_pix && !word) begin
                        half <= ~half;
                        word <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (draw) state_nx = ST_FETCH;
            ST_FETCH: if (bus.rom_ok) state_nx = ST_DRAW;
            ST_DRAW:  if (last_pix) state_nx = word ? ST_IDLE : ST_FETCH;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Flipped objects consume the word from the low nibble upward
    assign busy         = (state != ST_IDLE);
    assign bus.rom_cs   = (state == ST_FETCH);
    assign bus.rom_addr = {code_l, half};
    assign bus.buf_we   = (state == ST_DRAW);
    assign bus.buf_addr = addr;
    assign bus.buf_data = {pal_l, hflip_l ? pix_sr[3:0] : pix_sr[31:28]};

endmodule

// File: tb/tb_jtframe_obj_draw.sv
// tb/tb_jtframe_obj_draw.sv - directed self-checking bench for jtframe_obj_draw
module tb_jtframe_obj_draw;
    localparam int AW   = 9;
    localparam int CW   = 12;
    localparam int PALW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            draw = 1'b0;
    logic [CW-1:0]   code = '0;
    logic [AW-1:0]   xpos = '0;
    logic [PALW-1:0] pal = '0;
    logic            hflip = 1'b0;
    logic            busy;

    int checks = 0;
    int errors = 0;
    int rom_delay = 0;
    int wait_cnt = 0;
    logic [CW:0] held_addr = '0;
    logic [AW-1:0]   wa_q[$];
    logic [PALW+3:0] wd_q[$];

    jtframe_obj_draw_if #(.AW(AW), .CW(CW), .PALW(PALW)) bus();

    jtframe_obj_draw #(.AW(AW), .CW(CW), .PALW(PALW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .draw  (draw),
        .code  (code),
        .xpos  (xpos),
        .pal   (pal),
        .hflip (hflip),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ROM model: half 0 holds 0x01234567, half 1 holds 0x89ABCDEF; rom_ok comes after rom_delay waiting cycles
    initial begin
        bus.rom_ok   = 1'b0;
        bus.rom_data = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.rom_cs) begin
                if (wait_cnt == 0) held_addr = bus.rom_addr;
                else begin
                    check("rom_addr_hold", 32'(bus.rom_addr), 32'(held_addr));
                    check("we_low_in_fetch", 32'(bus.buf_we), 32'd0);
                end
                if (wait_cnt >= rom_delay) begin
                    bus.rom_ok   = 1'b1;
                    bus.rom_data = bus.rom_addr[0] ? 32'h89AB_CDEF : 32'h0123_4567;
                    wait_cnt     = 0;
                end else begin
                    bus.rom_ok = 1'b0;
                    wait_cnt++;
                end
            end else begin
                bus.rom_ok = 1'b0;
                wait_cnt   = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.buf_we === 1'b1) begin
            wa_q.push_back(bus.buf_addr);
            wd_q.push_back(bus.buf_data);
        end
    end

    task automatic verify_writes(input logic [AW-1:0] x, input logic [PALW-1:0] p, input logic hf);
        logic [AW-1:0] ea;
        logic [3:0]    ep;
        check("write_count", 32'(wa_q.size()), 32'd16);
        for (int i = 0; i < 16 && i < wa_q.size(); i++) begin
            ea = x + AW'(i);
            ep = hf ? 4'(15 - i) : 4'(i);
            check($sformatf("buf_addr[%0d]", i), 32'(wa_q[i]), 32'(ea));
            check($sformatf("buf_data[%0d]", i), 32'(wd_q[i]), 32'({p, ep}));
        end
    endtask

    // Cycle 1 is the accept cycle; the count ends on the first cycle that shows busy=0
    task automatic run_draw(input logic [CW-1:0] c, input logic [AW-1:0] x, input logic [PALW-1:0] p,
                            input logic hf, input int dly, input int exp_cyc, input bit pulse);
        int cyc;
        rom_delay = dly;
        wa_q.delete();
        wd_q.delete();
        @(negedge clk);
        draw = 1'b1; code = c; xpos = x; pal = p; hflip = hf;
        @(negedge clk);
        draw = 1'b0;
        cyc = 2;
        check("busy_rise", 32'(busy), 32'd1);
        check("rom_cs_rise", 32'(bus.rom_cs), 32'd1);
        check("first_rom_addr", 32'(bus.rom_addr), 32'({c, hf}));
        while (busy === 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (pulse && (cyc == 5 || cyc == 11)) begin
                draw = 1'b1; code = ~c; xpos = x + AW'(100); pal = ~p; hflip = ~hf;
            end else begin
                draw = 1'b0;
            end
        end
        draw = 1'b0;
        check("duration", 32'(cyc), 32'(exp_cyc));
        verify_writes(x, p, hf);
    endtask

    initial begin
        int nwe;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rom_cs", 32'(bus.rom_cs), 32'd0);
        check("rst_buf_we", 32'(bus.buf_we), 32'd0);
        check("rst_buf_addr", 32'(bus.buf_addr), 32'd0);
        check("rst_buf_data", 32'(bus.buf_data), 32'd0);
        check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_draw(12'h123, 9'h010, 4'h3, 1'b0, 0, 20, 1'b0);
        run_draw(12'h123, 9'h010, 4'h3, 1'b1, 0, 20, 1'b0);
        run_draw(12'h0A5, 9'h1FC, 4'h3, 1'b0, 0, 20, 1'b0);
        // rom_ok on the fifth FETCH cycle of each word
        run_draw(12'h456, 9'h040, 4'h5, 1'b0, 4, 28, 1'b0);
        run_draw(12'h789, 9'h080, 4'hC, 1'b0, 0, 20, 1'b1);
        repeat (3) @(negedge clk);
        check("pulse_not_queued_busy", 32'(busy), 32'd0);
        check("pulse_not_queued_writes", 32'(wa_q.size()), 32'd16);

        wa_q.delete();
        wd_q.delete();
        rom_delay = 0;
        @(negedge clk);
        draw = 1'b1; code = 12'h321; xpos = 9'h020; pal = 4'h7; hflip = 1'b0;
        @(negedge clk);
        draw = 1'b0;
        nwe = 0;
        for (int i = 0; i < 50 && nwe < 3; i++) begin
            if (bus.buf_we === 1'b1) nwe++;
            if (nwe < 3) @(negedge clk);
        end
        check("reach_third_draw", 32'(nwe), 32'd3);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_buf_we", 32'(bus.buf_we), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rom_cs", 32'(bus.rom_cs), 32'd0);
        check("abort_buf_addr", 32'(bus.buf_addr), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_write_count", 32'(wa_q.size()), 32'd3);
        run_draw(12'h123, 9'h010, 4'h3, 1'b0, 0, 20, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
